l2_req_queue: RTL and testbench

- Buffers the L1 data cache's per-cycle next-level requests (26-bit line address + 2-bit command) into a FIFO.
- Presents them to the L2 interface with a valid/ready handshake.
- The data cache has no stall input, so this block absorbs L2 back-pressure. When full, it drops requests and counts each drop for the statistics module.
- Sits directly between the data cache request outputs and the L2 cache port.

---
 rtl/l2_req_queue.sv | 122 ++++++++++++
 tb/tb_l2_req_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_queue.sv
// L1 data-cache -> L2 request FIFO with overflow drop and event counters.
// Defining L2Q_MERGE_EN collapses a request identical to the newest queued entry.
module l2_req_queue #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ADDR_W = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cmd_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              l2_ready,
  output logic              l2_valid,
  output logic [1:0]        l2_cmd,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [PTR_W:0]    level,
  output logic              full,
  output logic [31:0]       enq_count,
  output logic [31:0]       drop_count,
`ifdef L2Q_MERGE_EN
  output logic [31:0]       merge_count,
`endif
  output logic [31:0]       illegal_count
);

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head;
  logic [PTR_W:0]  wr_ptr;
  logic [PTR_W:0]  rd_ptr;
  logic            empty;
  logic            legal;
  logic            illegal;
  logic            pop;
  logic            push;
  logic            drop;
  logic            merge;

  assign in_entry = '{cmd: cmd_in, addr: addr_in};
  assign legal    = (cmd_in == CMD_READ) || (cmd_in == CMD_WRITE);
  assign illegal  = (cmd_in == CMD_ILLEGAL);

  // The extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                 (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign level = wr_ptr - rd_ptr;

  assign l2_valid = !empty;
  assign pop      = l2_valid && l2_ready;
  assign head     = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    l2_cmd  = CMD_NOP;
    l2_addr = '0;
    if (l2_valid) begin
      l2_cmd  = head.cmd;
      l2_addr = head.addr;
    end
  end

`ifdef L2Q_MERGE_EN
  localparam logic [PTR_W:0] LVL_ONE = {{PTR_W{1'b0}}, 1'b1};

  entry_t last_q;
  logic   newest_leaving;

  // The newest entry is leaving only when it is also the head being popped.
  assign newest_leaving = pop && (level == LVL_ONE);
  assign merge = legal && !empty && !newest_leaving && (in_entry == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= '0;
      merge_count <= '0;
    end else begin
      if (push)  last_q      <= in_entry;
      if (merge) merge_count <= merge_count + 32'd1;
    end
  end
`else
  assign merge = 1'b0;
`endif

  // Merge is checked first, so a merged request on a full queue is never a drop.
  assign push = legal && !merge && (!full || pop);
  assign drop = legal && !merge && full && !pop;

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      enq_count     <= '0;
      drop_count    <= '0;
      illegal_count <= '0;
    end else begin
      if (push)    wr_ptr        <= wr_ptr + 1'b1;
      if (pop)     rd_ptr        <= rd_ptr + 1'b1;
      if (push)    enq_count     <= enq_count + 32'd1;
      if (drop)    drop_count    <= drop_count + 32'd1;
      if (illegal) illegal_count <= illegal_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_l2_req_queue.sv
// Directed bench for l2_req_queue: expected head entries go into a scoreboard
// queue that a negedge monitor pops on every accepted handshake.
module tb_l2_req_queue;

  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int ADDR_W = 26;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        cmd_in = 2'b00;
  logic [ADDR_W-1:0] addr_in = '0;
  logic              l2_ready = 1'b0;
  logic              l2_valid;
  logic [1:0]        l2_cmd;
  logic [ADDR_W-1:0] l2_addr;
  logic [PTR_W:0]    level;
  logic              full;
  logic [31:0]       enq_count;
  logic [31:0]       drop_count;
  logic [31:0]       illegal_count;
`ifdef L2Q_MERGE_EN
  logic [31:0]       merge_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [27:0] exp_q [$];

  l2_req_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_in        (cmd_in),
    .addr_in       (addr_in),
    .l2_ready      (l2_ready),
    .l2_valid      (l2_valid),
    .l2_cmd        (l2_cmd),
    .l2_addr       (l2_addr),
    .level         (level),
    .full          (full),
    .enq_count     (enq_count),
    .drop_count    (drop_count),
`ifdef L2Q_MERGE_EN
    .merge_count   (merge_count),
`endif
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    cmd_in   = 2'b00;
    addr_in  = '0;
    l2_ready = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Drive one request for one cycle; accepted ones are recorded as expected heads.
  task automatic push_req(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr, input bit accepted);
    cmd_in  = cmd;
    addr_in = addr;
    if (accepted) exp_q.push_back({cmd, addr});
    step();
    cmd_in = 2'b00;
  endtask

  // Monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && l2_valid && l2_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_head: got %0h with nothing expected", {l2_cmd, l2_addr});
      end else begin
        check("head_entry", {4'h0, l2_cmd, l2_addr}, {4'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", {31'b0, l2_valid}, 32'd0);
    check("rst_cmd", {30'b0, l2_cmd}, 32'd0);
    check("rst_addr", {6'b0, l2_addr}, 32'd0);
    check("rst_level", {28'b0, level}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_counts", enq_count | drop_count | illegal_count, 32'd0);

    // Single READ: invisible in the push cycle, at head the next, then held
    cmd_in  = 2'b01;
    addr_in = 26'h0ABCDEF;
    exp_q.push_back({2'b01, 26'h0ABCDEF});
    check("no_bypass_valid", {31'b0, l2_valid}, 32'd0);
    step();
    cmd_in = 2'b00;
    check("t1_valid", {31'b0, l2_valid}, 32'd1);
    check("t1_level", {28'b0, level}, 32'd1);
    check("t1_enq", enq_count, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_hold_valid", {31'b0, l2_valid}, 32'd1);
      check("t1_hold_entry", {4'h0, l2_cmd, l2_addr}, {4'h0, 2'b01, 26'h0ABCDEF});
    end
    l2_ready = 1'b1;
    step();
    l2_ready = 1'b0;
    check("t1_empty_valid", {31'b0, l2_valid}, 32'd0);
    check("t1_empty_entry", {4'h0, l2_cmd, l2_addr}, 32'd0);

    // Nine WRITEs into an eight-entry queue with no drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push_req(2'b10, ADDR_W'(i), i < 8);
      if (i == 7) begin
        check("t2_full", {31'b0, full}, 32'd1);
        check("t2_level8", {28'b0, level}, 32'd8);
      end
    end
    check("t2_drop", drop_count, 32'd1);
    check("t2_enq", enq_count, 32'd8);
    check("t2_still_full", {31'b0, full}, 32'd1);
    l2_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("t2_drained", {31'b0, l2_valid}, 32'd0);
    step();
    check("t2_ready_when_empty", {28'b0, level}, 32'd0);
    l2_ready = 1'b0;

    // Push into a full queue while popping, then stream to wrap the pointers
    do_reset();
    for (int i = 0; i < 8; i++) push_req(2'b01, ADDR_W'(32'h10 + i), 1'b1);
    check("t3_full", {31'b0, full}, 32'd1);
    l2_ready = 1'b1;
    push_req(2'b10, 26'h3FFFFFF, 1'b1);
    check("t3_level", {28'b0, level}, 32'd8);
    check("t3_nodrop", drop_count, 32'd0);
    for (int i = 0; i < 20; i++) push_req(i[0] ? 2'b01 : 2'b10, ADDR_W'(32'h200 + i), 1'b1);
    check("t3_stream_level", {28'b0, level}, 32'd8);
    for (int i = 0; i < 8; i++) step();
    check("t3_empty", {31'b0, l2_valid}, 32'd0);
    check("t3_enq", enq_count, 32'd29);
    check("t3_drop", drop_count, 32'd0);
    l2_ready = 1'b0;

    // Illegal commands are counted, never queued
    do_reset();
    cmd_in = 2'b11;
    addr_in = 26'h123;
    for (int i = 0; i < 3; i++) step();
    cmd_in = 2'b00;
    check("t4_illegal", illegal_count, 32'd3);
    check("t4_level", {28'b0, level}, 32'd0);
    check("t4_valid", {31'b0, l2_valid}, 32'd0);
    check("t4_enq", enq_count, 32'd0);

    // Asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 7; i++) push_req(2'b01, ADDR_W'(32'h40 + i), 1'b1);
    l2_ready = 1'b1;
    step();
    step();
    check("t5_level5", {28'b0, level}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", {31'b0, l2_valid}, 32'd0);
    check("t5_async_level", {28'b0, level}, 32'd0);
    check("t5_async_enq", enq_count, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    l2_ready = 1'b0;
    push_req(2'b01, 26'h55, 1'b1);
    check("t5_alone_level", {28'b0, level}, 32'd1);
    check("t5_alone_entry", {4'h0, l2_cmd, l2_addr}, {4'h0, 2'b01, 26'h55});
    l2_ready = 1'b1;
    step();
    l2_ready = 1'b0;
    check("t5_alone_drained", {31'b0, l2_valid}, 32'd0);

    // Back-to-back identical WRITEs followed by a READ to the same line
    do_reset();
`ifdef L2Q_MERGE_EN
    push_req(2'b10, 26'h100, 1'b1);
    push_req(2'b10, 26'h100, 1'b0);
    push_req(2'b01, 26'h100, 1'b1);
    check("t6_level", {28'b0, level}, 32'd2);
    check("t6_merge", merge_count, 32'd1);
    check("t6_enq", enq_count, 32'd2);
`else
    push_req(2'b10, 26'h100, 1'b1);
    push_req(2'b10, 26'h100, 1'b1);
    push_req(2'b01, 26'h100, 1'b1);
    check("t6_level", {28'b0, level}, 32'd3);
    check("t6_enq", enq_count, 32'd3);
`endif
    l2_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    l2_ready = 1'b0;
    check("t6_drained", {31'b0, l2_valid}, 32'd0);

    check("scoreboard_left", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
